// File: rtl/proc_pkg.sv
// Shared types for the memory stage: memory-op codes, stack-sequencer states
// and flag bit positions within the {C,N,Z} flags word.
package proc_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAG_N  = 1;
    localparam int unsigned FLAG_Z  = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_LDD  = 4'd1,
        OP_STD  = 4'd2,
        OP_PUSH = 4'd3,
        OP_POP  = 4'd4,
        OP_CALL = 4'd5,
        OP_RET  = 4'd6,
        OP_INT  = 4'd7,
        OP_RTI  = 4'd8
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_LO  = 3'd1,
        ST_PUSH_FLG = 3'd2,
        ST_POP_LO   = 3'd3,
        ST_POP_HI   = 3'd4
    } state_e;

    // Unassigned encodings behave as NOP.
    function automatic mem_op_e decode_op(input logic [OP_W-1:0] raw);
        mem_op_e op;
        op = OP_NOP;
        if (raw <= OP_RTI) op = mem_op_e'(raw);
        return op;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Data memory: synchronous write, combinational read, single shared address.
// Ports: clk_i, we_i, addr_i, wdata_i -> rdata_o (contents of mem[addr_i]).
module data_memory #(
    parameter int unsigned W      = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [W-1:0]      wdata_i,
    output logic [W-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// Memory stage: data-memory loads/stores, single-word PUSH/POP and sequenced
// multi-word stack ops (CALL/RET/INT/RTI) with upstream stall.
// Inputs : clk, rst (async, active low), mem_op, alu_result, store_data,
//          flags_in, pc_in, wb_en_in, rd_in.
// Outputs: stall (combinational), alu_mw, mem_data, wb_en_out, rd_out,
//          flags_wb, flags_restore, pc_restore_valid, pc_restore, sp,
//          stack_fault (only when MEM_STACK_CHECK_EN is defined).
module memory_stage
    import proc_pkg::*;
#(
    parameter int unsigned W        = 16,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned SP_RESET = 2**ADDR_W - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_W-1:0]      mem_op,
    input  logic [W-1:0]         alu_result,
    input  logic [W-1:0]         store_data,
    input  logic [FLAGS_W-1:0]   flags_in,
    input  logic [2*W-1:0]       pc_in,
    input  logic                 wb_en_in,
    input  logic [2:0]           rd_in,
    output logic                 stall,
    output logic [W-1:0]         alu_mw,
    output logic [W-1:0]         mem_data,
    output logic                 wb_en_out,
    output logic [2:0]           rd_out,
    output logic                 flags_wb,
    output logic [FLAGS_W-1:0]   flags_restore,
    output logic                 pc_restore_valid,
    output logic [2*W-1:0]       pc_restore,
    output logic [ADDR_W-1:0]    sp
`ifdef MEM_STACK_CHECK_EN
    ,
    output logic                 stack_fault
`endif
);

    state_e              state_q, state_d;
    mem_op_e             op_q, op_d, cur_op;
    logic [W-1:0]        push_lo_q, push_lo_d;
    logic [FLAGS_W-1:0]  flags_lat_q, flags_lat_d;
    logic [W-1:0]        pop_lo_q, pop_lo_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [W-1:0]        alu_mw_q, alu_mw_d, mem_data_q, mem_data_d;
    logic                wb_en_q, wb_en_d, flags_wb_q, flags_wb_d;
    logic [2:0]          rd_q, rd_d;
    logic [FLAGS_W-1:0]  flags_restore_q, flags_restore_d;
    logic                pcv_q, pcv_d;
    logic [2*W-1:0]      pc_restore_q, pc_restore_d;
    logic                fault_q, fault_d;

    logic                do_push, do_pop, is_std, fault_c, stack_ctl;
    logic [W-1:0]        push_val;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [W-1:0]        mem_wdata, mem_rdata;

    data_memory #(.W(W), .ADDR_W(ADDR_W)) u_dmem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // Memory access selection: which word this cycle pushes/pops, and sp update.
    always_comb begin
        cur_op   = (state_q == ST_IDLE) ? decode_op(mem_op) : op_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        is_std   = 1'b0;
        push_val = store_data;
        unique case (state_q)
            ST_IDLE: begin
                unique case (cur_op)
                    OP_STD:  is_std = 1'b1;
                    OP_PUSH: do_push = 1'b1;
                    OP_CALL, OP_INT: begin
                        do_push  = 1'b1;
                        push_val = pc_in[2*W-1:W];
                    end
                    OP_POP, OP_RET, OP_RTI: do_pop = 1'b1;
                    default: ;
                endcase
            end
            ST_PUSH_LO: begin
                do_push  = 1'b1;
                push_val = push_lo_q;
            end
            ST_PUSH_FLG: begin
                do_push  = 1'b1;
                push_val = W'(flags_lat_q);
            end
            ST_POP_LO, ST_POP_HI: do_pop = 1'b1;
            default: ;
        endcase
`ifdef MEM_STACK_CHECK_EN
        fault_c = (do_push && (sp_q == '0)) || (do_pop && (sp_q == ADDR_W'(SP_RESET)));
`else
        fault_c = 1'b0;
`endif
        // Pop reads the pre-incremented sp so the read and the sp update agree.
        mem_addr  = do_push ? sp_q : (do_pop ? sp_q + ADDR_W'(1) : alu_result[ADDR_W-1:0]);
        mem_wdata = do_push ? push_val : store_data;
        mem_we    = is_std || (do_push && !fault_c);
        sp_d      = sp_q;
        if (!fault_c) begin
            if (do_push)     sp_d = sp_q - ADDR_W'(1);
            else if (do_pop) sp_d = sp_q + ADDR_W'(1);
        end
        fault_d = fault_q | fault_c;
    end

    // Sequencer next state, stall and registered-output next values.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        push_lo_d       = push_lo_q;
        flags_lat_d     = flags_lat_q;
        pop_lo_d        = pop_lo_q;
        stall           = 1'b0;
        mem_data_d      = mem_data_q;
        flags_wb_d      = 1'b0;
        flags_restore_d = flags_restore_q;
        pcv_d           = 1'b0;
        pc_restore_d    = pc_restore_q;
        alu_mw_d        = alu_mw_q;
        rd_d            = rd_q;
        wb_en_d         = wb_en_q;
        stack_ctl       = cur_op inside {OP_PUSH, OP_CALL, OP_RET, OP_INT, OP_RTI};
        unique case (state_q)
            ST_IDLE: begin
                unique case (cur_op)
                    OP_LDD: mem_data_d = mem_rdata;
                    OP_POP: if (!fault_c) mem_data_d = mem_rdata;
                    OP_CALL, OP_INT: begin
                        op_d        = cur_op;
                        push_lo_d   = pc_in[W-1:0];
                        flags_lat_d = flags_in;
                        stall       = 1'b1;
                        state_d     = ST_PUSH_LO;
                    end
                    OP_RET: begin
                        op_d     = cur_op;
                        pop_lo_d = mem_rdata;
                        stall    = 1'b1;
                        state_d  = ST_POP_HI;
                    end
                    OP_RTI: begin
                        op_d            = cur_op;
                        flags_restore_d = {mem_rdata[FLAG_C], mem_rdata[FLAG_N], mem_rdata[FLAG_Z]};
                        flags_wb_d      = 1'b1;
                        stall           = 1'b1;
                        state_d         = ST_POP_LO;
                    end
                    default: ;
                endcase
            end
            ST_PUSH_LO: begin
                if (op_q == OP_INT) begin
                    stall   = 1'b1;
                    state_d = ST_PUSH_FLG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH_FLG: state_d = ST_IDLE;
            ST_POP_LO: begin
                pop_lo_d = mem_rdata;
                stall    = 1'b1;
                state_d  = ST_POP_HI;
            end
            ST_POP_HI: begin
                pc_restore_d = {mem_rdata, pop_lo_q};
                pcv_d        = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Pipeline payload advances only when upstream is not being held.
        if (!stall) begin
            alu_mw_d = alu_result;
            rd_d     = rd_in;
            wb_en_d  = wb_en_in && !stack_ctl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            op_q            <= OP_NOP;
            push_lo_q       <= '0;
            flags_lat_q     <= '0;
            pop_lo_q        <= '0;
            sp_q            <= ADDR_W'(SP_RESET);
            alu_mw_q        <= '0;
            mem_data_q      <= '0;
            wb_en_q         <= 1'b0;
            rd_q            <= '0;
            flags_wb_q      <= 1'b0;
            flags_restore_q <= '0;
            pcv_q           <= 1'b0;
            pc_restore_q    <= '0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            push_lo_q       <= push_lo_d;
            flags_lat_q     <= flags_lat_d;
            pop_lo_q        <= pop_lo_d;
            sp_q            <= sp_d;
            alu_mw_q        <= alu_mw_d;
            mem_data_q      <= mem_data_d;
            wb_en_q         <= wb_en_d;
            rd_q            <= rd_d;
            flags_wb_q      <= flags_wb_d;
            flags_restore_q <= flags_restore_d;
            pcv_q           <= pcv_d;
            pc_restore_q    <= pc_restore_d;
            fault_q         <= fault_d;
        end
    end

    assign alu_mw           = alu_mw_q;
    assign mem_data         = mem_data_q;
    assign wb_en_out        = wb_en_q;
    assign rd_out           = rd_q;
    assign flags_wb         = flags_wb_q;
    assign flags_restore    = flags_restore_q;
    assign pc_restore_valid = pcv_q;
    assign pc_restore       = pc_restore_q;
    assign sp               = sp_q;
`ifdef MEM_STACK_CHECK_EN
    assign stack_fault      = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule
